// File: rtl/dt_arb_pkg.sv
// Shared types and defaults for the decision-tree classifier arbiter.
// Imported by the arbiter top and its round-robin picker.
package dt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_IN_W  = 9;
    localparam int DEF_OUT_W = 5;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dt_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around, as one-hot grant plus index.
module dt_rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW:0] k;

    // Scan downward so the lowest offset from ptr is the last to win.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            k = {1'b0, ptr} + (PW + 1)'(i);
            if (k >= (PW + 1)'(N))
                k = k - (PW + 1)'(N);
            if (req[k[PW-1:0]]) begin
                gnt             = '0;
                gnt[k[PW-1:0]]  = 1'b1;
                idx             = k[PW-1:0];
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dt_classify_arbiter.sv
// Round-robin sharing of one combinational decision-tree classifier
// between NUM_REQ requesters, with a single id-tagged response channel.
module dt_classify_arbiter
    import dt_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [IN_W-1:0]         tree_inp,
    input  logic [OUT_W-1:0]        tree_outp,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   g;
    logic              any;
    logic              grant_ok;
    logic              take;
    logic [IN_W-1:0]   req_vec [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_vec[i] = req_data[i*IN_W +: IN_W];
    end

    dt_rr_pick #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (g),
        .any (any)
    );

    // No grant while in reset, so nothing transfers during that window.
    assign grant_ok  = !rst && ((state_q == IDLE) ||
                                (state_q == HOLD && rsp_ready));
    assign take      = grant_ok && any;
    assign req_ready = grant_ok ? gnt : '0;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any) state_d = EVAL;
            EVAL: state_d = HOLD;
            HOLD: if (rsp_ready) state_d = any ? EVAL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            tree_inp  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                tree_inp <= req_vec[g];
                id_q     <= g;
                ptr_q    <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            end
            if (state_q == EVAL) begin
                rsp_data  <= tree_outp;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end else if (state_q == HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
